// File: rtl/comb_sweep_driver.sv
// rtl/comb_sweep_driver.sv - drives all 8 input vectors of a 3-input circuit, samples X after a settle time, checks it
// against a truth table
module comb_sweep_driver #(
  parameter int         SETTLE_CYCLES = 4,
  parameter logic [7:0] EXP_TT        = 8'hE2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       x_in,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic [2:0] vec_idx,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] err_count,
  output logic [7:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      a         <= 1'b0;
      b         <= 1'b0;
      c         <= 1'b0;
      vec_idx   <= 3'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 4'd0;
      fail_vec  <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            vec_idx   <= 3'd0;
            {a, b, c} <= 3'b000;
            cnt       <= 4'd0;
            err_count <= 4'd0;
            fail_vec  <= 8'd0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            state     <= SETTLE;
          end
        end
        SETTLE: begin
          cnt <= cnt + 4'd1;
          if (cnt == CNT_LAST) state <= SAMPLE;
        end
        SAMPLE: begin
          if (x_in != EXP_TT[vec_idx]) begin
            fail_vec[vec_idx] <= 1'b1;
            err_count         <= err_count + 4'd1;
          end
          if (vec_idx == 3'd7) begin
            state <= DONE;
          end else begin
            // the next vector is driven on the same edge so vectors follow back to back
            vec_idx   <= vec_idx + 3'd1;
            {a, b, c} <= vec_idx + 3'd1;
            cnt       <= 4'd0;
            state     <= SETTLE;
          end
        end
        DONE: begin
          done      <= 1'b1;
          pass      <= (err_count == 4'd0);
          busy      <= 1'b0;
          vec_idx   <= 3'd0;
          {a, b, c} <= 3'b000;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_comb_sweep_driver.sv
// tb/tb_comb_sweep_driver.sv - scoreboard bench for comb_sweep_driver with settle 4 and settle 2 instances
module tb_comb_sweep_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_s   [2];
  logic       x_s       [2];
  logic       a_s       [2];
  logic       b_s       [2];
  logic       c_s       [2];
  logic [2:0] vec_s     [2];
  logic       busy_s    [2];
  logic       done_s    [2];
  logic       pass_s    [2];
  logic [3:0] err_s     [2];
  logic [7:0] fv_s      [2];
  logic [7:0] hist      [2];
  int         mode_s    [2];
  int         cyc = 0;
  bit         mon_en = 1'b0;
  int         passed = 0;
  int         total = 0;

  typedef struct {
    int         dut;
    int         start_edge;
    int         settle;
    logic [7:0] fv;
    int         errc;
    bit         pass;
  } rec_t;
  rec_t q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  comb_sweep_driver dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_s[0]), .x_in(x_s[0]),
    .a(a_s[0]), .b(b_s[0]), .c(c_s[0]), .vec_idx(vec_s[0]), .busy(busy_s[0]),
    .done(done_s[0]), .pass(pass_s[0]), .err_count(err_s[0]), .fail_vec(fv_s[0])
  );

  comb_sweep_driver #(.SETTLE_CYCLES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_s[1]), .x_in(x_s[1]),
    .a(a_s[1]), .b(b_s[1]), .c(c_s[1]), .vec_idx(vec_s[1]), .busy(busy_s[1]),
    .done(done_s[1]), .pass(pass_s[1]), .err_count(err_s[1]), .fail_vec(fv_s[1])
  );

  // the circuit under drive: X = A.B + ~B.C
  function automatic bit circ(input int v);
    bit aa, bb, cc;
    aa = v[2];
    bb = v[1];
    cc = v[0];
    return (aa & bb) | (~bb & cc);
  endfunction

  // modes: 0 correct, 1 tied low, 2 inverted, 3 correct but delayed by 3 cycles
  function automatic bit circ_out(input int md, input int v);
    case (md)
      1:       return 1'b0;
      2:       return ~circ(v);
      default: return circ(v);
    endcase
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      hist[d] <= {hist[d][6:0], circ(int'({a_s[d], b_s[d], c_s[d]}))};
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      x_s[d] = 1'b0;
      case (mode_s[d])
        0: x_s[d] = circ(int'({a_s[d], b_s[d], c_s[d]}));
        1: x_s[d] = 1'b0;
        2: x_s[d] = ~circ(int'({a_s[d], b_s[d], c_s[d]}));
        default: x_s[d] = hist[d][3];
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Each vector is held settle+1 cycles and X is captured in the last one; a circuit
  // delay of D cycles therefore shows the value of the vector driven settle-D cycles
  // into the hold, or the previous vector if that offset is negative.
  function automatic rec_t make_rec(input int d, input int md);
    rec_t       r;
    logic [7:0] exp_tt;
    int         dly, sv;
    exp_tt = 8'hE2;
    dly    = (md == 3) ? 3 : 0;
    r.dut        = d;
    r.start_edge = cyc + 1;
    r.settle     = (d == 0) ? 4 : 2;
    r.fv         = 8'd0;
    r.errc       = 0;
    for (int v = 0; v < 8; v++) begin
      sv = (r.settle - dly >= 0) ? v : ((v == 0) ? 0 : v - 1);
      if (circ_out(md, sv) != exp_tt[v]) begin
        r.fv[v] = 1'b1;
        r.errc++;
      end
    end
    r.pass = (r.errc == 0);
    return r;
  endfunction

  task automatic run_sweep(input int d, input int md, input bit hold);
    bit got;
    mode_s[d] = md;
    repeat ($urandom_range(4, 1)) @(negedge clk);
    q.push_back(make_rec(d, md));
    start_s[d] = 1'b1;
    if (!hold) begin
      @(negedge clk);
      start_s[d] = 1'b0;
    end
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done_s[d]) got = 1'b1;
    end
    start_s[d] = 1'b0;
    if (!got) begin
      total++;
      $display("FAIL sweep_timeout dut%0d: no done within 200 cycles", d);
    end
    repeat (3) @(negedge clk);
  endtask

  // monitor: per-cycle vector order and busy, plus results and latency at done
  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < 2; d++) begin
        int   qi, k, len, v;
        rec_t r;
        qi = -1;
        for (int i = 0; i < q.size(); i++)
          if (q[i].dut == d && qi < 0) qi = i;
        if (qi < 0) begin
          chk($sformatf("idle_busy%0d", d), 32'(busy_s[d]), 0);
          chk($sformatf("idle_done%0d", d), 32'(done_s[d]), 0);
        end else begin
          r   = q[qi];
          k   = cyc - r.start_edge;
          len = 8 * (r.settle + 1) + 1;
          if (k < 0) begin
            chk($sformatf("pre_busy%0d", d), 32'(busy_s[d]), 0);
          end else if (done_s[d]) begin
            chk($sformatf("latency%0d", d), k, len);
            chk($sformatf("err_count%0d", d), 32'(err_s[d]), r.errc);
            chk($sformatf("fail_vec%0d", d), 32'(fv_s[d]), 32'(r.fv));
            chk($sformatf("pass%0d", d), 32'(pass_s[d]), 32'(r.pass));
            chk($sformatf("done_busy%0d", d), 32'(busy_s[d]), 0);
            chk($sformatf("done_vec%0d", d), 32'({vec_s[d], a_s[d], b_s[d], c_s[d]}), 0);
            q.delete(qi);
          end else if (k >= len) begin
            total++;
            $display("FAIL no_done%0d: still waiting %0d cycles after start, expected %0d", d, k, len);
            q.delete(qi);
          end else begin
            v = k / (r.settle + 1);
            if (v > 7) v = 7;
            chk($sformatf("run_busy%0d", d), 32'(busy_s[d]), 1);
            chk($sformatf("vec_idx%0d", d), 32'(vec_s[d]), v);
            chk($sformatf("abc%0d", d), 32'({a_s[d], b_s[d], c_s[d]}), v);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk_reset(input int d);
    chk($sformatf("rst_abc%0d", d), 32'({a_s[d], b_s[d], c_s[d]}), 0);
    chk($sformatf("rst_vec%0d", d), 32'(vec_s[d]), 0);
    chk($sformatf("rst_flags%0d", d), 32'({busy_s[d], done_s[d], pass_s[d]}), 0);
    chk($sformatf("rst_err%0d", d), 32'(err_s[d]), 0);
    chk($sformatf("rst_fv%0d", d), 32'(fv_s[d]), 0);
  endtask

  initial begin
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0;
      mode_s[d]  = 0;
    end
    #3 rst_n = 1'b0;
    #1 chk_reset(0);
    chk_reset(1);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    repeat (5) @(negedge clk);

    run_sweep(0, 0, 1'b0);
    run_sweep(0, 1, 1'b0);
    run_sweep(0, 2, 1'b1);
    run_sweep(1, 3, 1'b0);
    run_sweep(0, 3, 1'b0);
    run_sweep(1, 0, 1'b1);

    mode_s[0] = 1;
    @(negedge clk);
    q.push_back(make_rec(0, 1));
    start_s[0] = 1'b1;
    @(negedge clk);
    start_s[0] = 1'b0;
    for (int i = 0; i < 100 && vec_s[0] != 3'd3; i++) @(negedge clk);
    chk("reach_vec3", 32'(vec_s[0]), 3);
    #2 rst_n = 1'b0;
    #1 chk_reset(0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    run_sweep(0, 0, 1'b0);

    repeat (5) begin
      int d, md;
      d  = int'($urandom_range(1, 0));
      md = int'($urandom_range(3, 0));
      run_sweep(d, md, 1'($urandom_range(1, 0)));
    end

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
